// File: rtl/wb_sdram_txq_reader_pkg.sv
// Shared field layout, encodings and FSM states for the SDRAM-side tx FIFO reader.
package wb_sdram_txq_reader_pkg;

    localparam int HDR_ADR_LSB = 6;
    localparam int HDR_WE_BIT  = 5;
    localparam int HDR_BTE_LSB = 3;
    localparam int DAT_LSB     = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HWAIT = 2'd1;
    localparam logic [1:0] ST_CMD   = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    // Linear incrementing bursts are re-headered per beat, so only wrap bursts are long.
    function automatic logic [4:0] burst_len(input logic [2:0] cti, input logic [1:0] bte);
        burst_len = 5'd1;
        if (cti == CTI_INCR) begin
            case (bte)
                BTE_WRAP4:  burst_len = 5'd4;
                BTE_WRAP8:  burst_len = 5'd8;
                BTE_WRAP16: burst_len = 5'd16;
                default:    burst_len = 5'd1;
            endcase
        end
    endfunction

endpackage

// File: rtl/wb_sdram_wdat_skid.sv
// Two-entry write-data skid buffer; entries arrive one cycle after the FIFO pop.
module wb_sdram_wdat_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [35:0] wr_data,
    input  logic        rd_en,
    output logic        valid,
    output logic [35:0] head,
    output logic [1:0]  occ
);

    logic [35:0] mem [2];
    logic        wptr;
    logic        rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= ~wptr;
            end
            if (rd_en) begin
                rptr <= ~rptr;
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign valid = (occ != 2'd0);
    assign head  = mem[rptr];

endmodule

// File: rtl/wb_sdram_txq_reader.sv
// Round-robin drain of the multi-channel tx FIFO into SDRAM commands plus a
// write-data stream, running entirely in the sdram_clk domain.
module wb_sdram_txq_reader
    import wb_sdram_txq_reader_pkg::*;
#(
    parameter int         NR_PORTS = 8,
    parameter logic [7:0] PORT_EN  = 8'hFF
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic [7:0]  fifo_empty_i,
    input  logic [35:0] fifo_dat_i,
    output logic        fifo_re_o,
    output logic [2:0]  fifo_sel_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [29:0] cmd_adr_o,
    output logic        cmd_we_o,
    output logic [4:0]  cmd_len_o,
    output logic [1:0]  cmd_bte_o,
    output logic [2:0]  cmd_port_o,
    output logic        wdat_valid_o,
    input  logic        wdat_ready_i,
    output logic [31:0] wdat_o,
    output logic [3:0]  wsel_o,
    output logic        wdat_last_o
);

    logic [1:0]  state;
    logic [2:0]  rr;
    logic [2:0]  sel_q;
    logic [2:0]  grant;
    logic        any_elig;
    logic [4:0]  req_left;
    logic [4:0]  beat_left;
    logic        inflight;
    logic        data_pop;
    logic        accept;
    logic [1:0]  occ;
    logic [35:0] head;

    // Scan starts just past the last grant so every eligible channel gets a turn.
    always_comb begin
        logic [2:0] cand;
        cand     = 3'd0;
        grant    = rr;
        any_elig = 1'b0;
        for (int i = 1; i <= NR_PORTS; i++) begin
            cand = 3'((int'(rr) + i) % NR_PORTS);
            if (!any_elig && !fifo_empty_i[cand] && PORT_EN[cand]) begin
                any_elig = 1'b1;
                grant    = cand;
            end
        end
    end

    assign accept = wdat_valid_o & wdat_ready_i;

    // Crediting the beat leaving this cycle keeps a 1 beat/cycle stream going.
    assign data_pop = (state == ST_DATA) && !fifo_empty_i[sel_q] && (req_left != 5'd0)
                      && (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, accept}));

    assign fifo_re_o  = !sdram_rst && (((state == ST_IDLE) && any_elig) || data_pop);
    assign fifo_sel_o = ((state == ST_IDLE) && any_elig && !sdram_rst) ? grant : sel_q;

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state       <= ST_IDLE;
            rr          <= 3'd7;
            sel_q       <= 3'd0;
            cmd_valid_o <= 1'b0;
            cmd_adr_o   <= '0;
            cmd_we_o    <= 1'b0;
            cmd_len_o   <= 5'd0;
            cmd_bte_o   <= 2'd0;
            cmd_port_o  <= 3'd0;
            req_left    <= 5'd0;
            beat_left   <= 5'd0;
            inflight    <= 1'b0;
        end else begin
            inflight <= data_pop;
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        sel_q <= grant;
                        rr    <= grant;
                        state <= ST_HWAIT;
                    end
                end
                ST_HWAIT: begin
                    cmd_adr_o   <= fifo_dat_i[35:HDR_ADR_LSB];
                    cmd_we_o    <= fifo_dat_i[HDR_WE_BIT];
                    cmd_bte_o   <= fifo_dat_i[HDR_BTE_LSB +: 2];
                    cmd_len_o   <= burst_len(fifo_dat_i[2:0], fifo_dat_i[HDR_BTE_LSB +: 2]);
                    cmd_port_o  <= sel_q;
                    cmd_valid_o <= 1'b1;
                    state       <= ST_CMD;
                end
                ST_CMD: begin
                    if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        if (cmd_we_o) begin
                            req_left  <= cmd_len_o;
                            beat_left <= cmd_len_o;
                            state     <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (data_pop) begin
                        req_left <= req_left - 5'd1;
                    end
                    if (accept) begin
                        beat_left <= beat_left - 5'd1;
                        if (beat_left == 5'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    wb_sdram_wdat_skid u_skid (
        .clk     (sdram_clk),
        .rst     (sdram_rst),
        .wr_en   (inflight),
        .wr_data (fifo_dat_i),
        .rd_en   (accept),
        .valid   (wdat_valid_o),
        .head    (head),
        .occ     (occ)
    );

    assign wdat_o      = head[35:DAT_LSB];
    assign wsel_o      = head[DAT_LSB-1:0];
    assign wdat_last_o = wdat_valid_o && (beat_left == 5'd1);

endmodule
